pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CTRL_W  8   width of control bundle (regWrite, memtoReg, memWrite, sb, lh, zeroFlag, branch[1:0])
  DATA_W  69  width of data bundle (readData2, ALUresult, rd)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk        in   1       single clock; all state updates on rising edge
  reset      in   1       asynchronous, active-high reset
  flush      in   1       synchronous squash of all held entries
  in_valid   in   1       upstream entry valid
  in_ready   out  1       block can accept an entry this cycle
  in_ctrl    in   CTRL_W  upstream control bundle
  in_data    in   DATA_W  upstream data bundle
  out_valid  out  1       output entry valid
  out_ready  in   1       downstream accepts the output entry this cycle
  out_ctrl   out  CTRL_W  output control bundle
  out_data   out  DATA_W  output data bundle
  occupancy  out  2       number of held entries, 0..2
REQ-003 The block SHALL be parametrisable with CTRL_W >= 1 and DATA_W >= 1, with no other width assumptions.

Function
REQ-004 Storage SHALL be two entries: an output register (out_*) and one skid register, each with its own valid bit.
REQ-005 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-006 in_ready SHALL be driven directly from a register, equal to !skid_valid, with no combinational path from out_ready.
REQ-007 The state SHALL be one of EMPTY (occupancy 0), ONE (1), FULL (2); occupancy SHALL equal the state encoding.
REQ-008 EMPTY: on input transfer -> load output register, go to ONE; otherwise stay.
REQ-009 ONE: input and output transfer -> load output register from input, stay ONE; input only -> load skid, go FULL; output only -> EMPTY; neither -> hold.
REQ-010 FULL: in_ready=0; on output transfer -> move skid into output register, go ONE; otherwise hold all contents.
REQ-011 Latency SHALL be 1 cycle from input transfer to out_valid when the output register is empty or draining; order SHALL be strictly FIFO.
REQ-012 Whenever out_valid=0, out_ctrl SHALL be all-zero (registered, not gated combinationally), so that a bubble never asserts regWrite or memWrite downstream.
REQ-013 out_data SHALL hold its last value while out_valid=0.
REQ-014 While out_valid=1 && out_ready=0, out_ctrl and out_data SHALL remain stable.
REQ-015 flush=1 SHALL take priority over all transfers: next state EMPTY, out_ctrl zeroed, and any in_valid entry in that cycle discarded.
REQ-016 During a flush cycle, in_ready SHALL keep its registered value, and an accepted input SHALL still be dropped.
REQ-017 No entry SHALL be lost or duplicated under any in_valid/out_ready pattern, absent flush.

Reset
REQ-018 While reset=1, irrespective of clk: state EMPTY, out_valid=0, skid_valid=0, in_ready=1, occupancy=0, out_ctrl=0, out_data=0, skid contents=0.
REQ-019 Reset asserted mid-operation SHALL discard all held entries immediately; the first input transfer after deassertion SHALL be accepted normally.

Verification
REQ-020 Streaming: out_ready=1, in_valid=1 for 10 cycles, in_data=1..10 -> out_data 1..10 one cycle later, in_ready constantly 1, occupancy 1.
REQ-021 Backpressure: with A held and out_ready=0, send B -> occupancy 2, in_ready=0; raise out_ready -> A then B on consecutive cycles, in_ready=1 after A leaves.
REQ-022 Bubble gating: in_valid=0 with in_ctrl=8'hFF -> out_valid=0 and out_ctrl=8'h00 every cycle.
REQ-023 Flush when FULL with in_valid=1 (C) -> next cycle occupancy 0, out_valid=0, out_ctrl=0, and C never appears at the output.
REQ-024 Async reset: assert reset between clock edges while FULL -> out_valid=0, in_ready=1, occupancy=0 before the next edge.
REQ-025 Random in_valid/out_ready for 10k cycles against a FIFO scoreboard -> zero mismatches, occupancy always <= 2.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with a skid buffer. in_ready comes straight from a flop,
// and out_ctrl is zeroed in its register whenever the output holds a bubble.
module pipe_skid_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 69
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, next_state;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl, next_skid_ctrl, next_out_ctrl;
    logic [DATA_W-1:0] skid_data, next_skid_data, next_out_data;
    logic              in_xfer, out_xfer;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign in_ready  = ~skid_valid;
    assign occupancy = state;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        next_state     = state;
        next_out_ctrl  = out_ctrl;
        next_out_data  = out_data;
        next_skid_ctrl = skid_ctrl;
        next_skid_data = skid_data;
        if (flush) begin
            // Squash wins over everything; a same-cycle input is dropped.
            next_state    = EMPTY;
            next_out_ctrl = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        next_out_ctrl = in_ctrl;
                        next_out_data = in_data;
                        next_state    = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        next_out_ctrl = in_ctrl;
                        next_out_data = in_data;
                    end else if (in_xfer) begin
                        next_skid_ctrl = in_ctrl;
                        next_skid_data = in_data;
                        next_state     = FULL;
                    end else if (out_xfer) begin
                        next_out_ctrl = '0;
                        next_state    = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        next_out_ctrl = skid_ctrl;
                        next_out_data = skid_data;
                        next_state    = ONE;
                    end
                end
                default: begin
                    next_out_ctrl = '0;
                    next_state    = EMPTY;
                end
            endcase
        end
    end

    // NOTE: the skid payload is reset too, so no stale value is ever visible after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_ctrl   <= '0;
            out_data   <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state      <= next_state;
            out_valid  <= (next_state != EMPTY);
            skid_valid <= (next_state == FULL);
            out_ctrl   <= next_out_ctrl;
            out_data   <= next_out_data;
            skid_ctrl  <= next_skid_ctrl;
            skid_data  <= next_skid_data;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized checks of pipe_skid_reg: streaming, backpressure, bubble gating,
// flush, asynchronous reset and a FIFO scoreboard run.
module tb_pipe_skid_reg;

    localparam int CW = 8;
    localparam int DW = 69;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid  = v;
        out_ready = r;
        in_ctrl   = c;
        in_data   = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL reset_out_ctrl got=%h exp=0", out_ctrl); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b1, CW'(i + 8'h10), DW'(i));
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== CW'(i + 8'h10))
                begin failures++; $display("FAIL stream_out[%0d] got v=%b d=%0h c=%h exp v=1 d=%0h c=%h", i, out_valid, out_data, out_ctrl, i, CW'(i + 8'h10)); end
            checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
        end
        drive(1'b0, 1'b1, '0, '0);
        step();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0)
            begin failures++; $display("FAIL stream_drain got occ=%0d v=%b c=%h exp occ=0 v=0 c=00", occupancy, out_valid, out_ctrl); end
        checks++; if (out_data !== DW'(10)) begin failures++; $display("FAIL stream_hold_data got=%0h exp=a", out_data); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b0, 8'hA1, DW'(69'hA));
        step();
        checks++; if (occupancy !== 2'd1 || out_data !== DW'(69'hA)) begin failures++; $display("FAIL bp_a_loaded got occ=%0d d=%0h exp occ=1 d=a", occupancy, out_data); end
        drive(1'b1, 1'b0, 8'hB2, DW'(69'hB));
        step();
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready); end
        checks++; if (out_data !== DW'(69'hA) || out_ctrl !== 8'hA1) begin failures++; $display("FAIL bp_stall_a got d=%0h c=%h exp d=a c=a1", out_data, out_ctrl); end
        drive(1'b1, 1'b0, 8'hC3, DW'(69'hC));
        step();
        checks++; if (occupancy !== 2'd2 || out_data !== DW'(69'hA) || out_ctrl !== 8'hA1)
            begin failures++; $display("FAIL bp_hold_full got occ=%0d d=%0h c=%h exp occ=2 d=a c=a1", occupancy, out_data, out_ctrl); end
        drive(1'b0, 1'b1, '0, '0);
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== DW'(69'hB) || out_ctrl !== 8'hB2)
            begin failures++; $display("FAIL bp_b_out got v=%b d=%0h c=%h exp v=1 d=b c=b2", out_valid, out_data, out_ctrl); end
        checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin failures++; $display("FAIL bp_ready_back got rdy=%b occ=%0d exp rdy=1 occ=1", in_ready, occupancy); end
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL bp_empty got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_bubble();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i[0], 8'hFF, {DW{1'b1}});
            step();
            checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00)
                begin failures++; $display("FAIL bubble[%0d] got v=%b c=%h exp v=0 c=00", i, out_valid, out_ctrl); end
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 8'h11, DW'(69'h1A));
        step();
        drive(1'b1, 1'b0, 8'h22, DW'(69'h1B));
        step();
        flush = 1'b1;
        drive(1'b1, 1'b1, 8'h33, DW'(69'h1C));
        step();
        flush = 1'b0;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1)
            begin failures++; $display("FAIL flush_full got occ=%0d v=%b c=%h rdy=%b exp occ=0 v=0 c=00 rdy=1", occupancy, out_valid, out_ctrl, in_ready); end
        checks++; if (out_data !== DW'(69'h1A)) begin failures++; $display("FAIL flush_hold_data got=%0h exp=1a", out_data); end
        drive(1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_c[%0d] got v=%b d=%0h exp v=0", i, out_valid, out_data); end
        end
        // Flush in ONE while in_ready=1: the accepted entry must be dropped.
        drive(1'b1, 1'b0, 8'h44, DW'(69'h1D));
        step();
        flush = 1'b1;
        drive(1'b1, 1'b0, 8'h55, DW'(69'h1E));
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_one_rdy got=%b exp=1", in_ready); end
        step();
        flush = 1'b0;
        drive(1'b0, 1'b1, '0, '0);
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_one got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_one_drop got v=%b d=%0h exp v=0", out_valid, out_data); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 8'h66, DW'(69'h2A));
        step();
        drive(1'b1, 1'b0, 8'h77, DW'(69'h2B));
        step();
        drive(1'b0, 1'b0, '0, '0);
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL areset_prefill got occ=%0d exp=2", occupancy); end
        #3 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0)
            begin failures++; $display("FAIL areset_imm got v=%b rdy=%b occ=%0d exp v=0 rdy=1 occ=0", out_valid, in_ready, occupancy); end
        checks++; if (out_ctrl !== '0 || out_data !== '0) begin failures++; $display("FAIL areset_payload got c=%h d=%0h exp 0", out_ctrl, out_data); end
        #1 reset = 1'b0;
        drive(1'b1, 1'b1, 8'h88, DW'(69'h2D));
        step();
        drive(1'b0, 1'b1, '0, '0);
        checks++; if (occupancy !== 2'd1 || out_data !== DW'(69'h2D) || out_ctrl !== 8'h88)
            begin failures++; $display("FAIL areset_first got occ=%0d d=%0h c=%h exp occ=1 d=2d c=88", occupancy, out_data, out_ctrl); end
        step();
    endtask

    task automatic test_random();
        entry_t q[$];
        entry_t e;
        logic   ix, ox;
        int     bad = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checks++;
            if (occupancy !== 2'(q.size()) || out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                bad++; failures++;
                if (bad <= 10) $display("FAIL rand_state[%0d] got occ=%0d v=%b rdy=%b exp occ=%0d", cyc, occupancy, out_valid, in_ready, q.size());
            end
            checks++;
            if (q.size() > 0) begin
                if (out_data !== q[0].data || out_ctrl !== q[0].ctrl) begin
                    bad++; failures++;
                    if (bad <= 10) $display("FAIL rand_data[%0d] got d=%0h c=%h exp d=%0h c=%h", cyc, out_data, out_ctrl, q[0].data, q[0].ctrl);
                end
            end else if (out_ctrl !== '0) begin
                bad++; failures++;
                if (bad <= 10) $display("FAIL rand_bubble[%0d] got c=%h exp 00", cyc, out_ctrl);
            end
            e.ctrl = CW'($urandom);
            e.data = DW'({$urandom, $urandom, $urandom});
            drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0 || cyc[8]), e.ctrl, e.data);
            ix = in_valid && (q.size() < 2);
            ox = out_ready && (q.size() > 0);
            step();
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(e);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
